// File: rtl/mac_seq_ctrl_if.sv
// Signal bundle between the layer scheduler / operand buffer / MAC array and the MAC sequencer.
// MAC_SEQ_PERF_EN adds the perf_stall counter output.
interface mac_seq_ctrl_if #(
  parameter int MAC_NUM = 120,
  parameter int LEN_W   = 8
);
  logic               start;
  logic [LEN_W-1:0]   cfg_len;
  logic [MAC_NUM-1:0] cfg_lane_mask;
  logic               op_vld;
  logic [LEN_W-1:0]   op_addr;
  logic [MAC_NUM-1:0] mac_en;
  logic               psum_sel;
  logic               acc_ld;
  logic               out_wr;
  logic               busy;
  logic               done;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0]        perf_stall;

  modport slave (
    input  start, cfg_len, cfg_lane_mask, op_vld,
    output op_addr, mac_en, psum_sel, acc_ld, out_wr, busy, done, perf_stall
  );
  modport master (
    output start, cfg_len, cfg_lane_mask, op_vld,
    input  op_addr, mac_en, psum_sel, acc_ld, out_wr, busy, done, perf_stall
  );
`else
  modport slave (
    input  start, cfg_len, cfg_lane_mask, op_vld,
    output op_addr, mac_en, psum_sel, acc_ld, out_wr, busy, done
  );
  modport master (
    output start, cfg_len, cfg_lane_mask, op_vld,
    input  op_addr, mac_en, psum_sel, acc_ld, out_wr, busy, done
  );
`endif
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC lane-array sequencer: runs one cfg_len-step dot-product job, pacing issues STEP_CYC apart.
// Optional MAC_SEQ_PERF_EN adds a saturating operand-stall counter on perf_stall.
module mac_seq_ctrl #(
  parameter int MAC_NUM  = 120,
  parameter int LEN_W    = 8,
  parameter int STEP_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_seq_ctrl_if.slave bus
);
  localparam int              GAP_W    = $clog2(STEP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STEP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   addr_q, addr_d;
  logic [MAC_NUM-1:0] mask_q, mask_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               zero_q, zero_d;
  // Per-issue tracking for T+1..T+3: valid, first-step and last-step flags.
  logic [2:0]         pv_q, pf_q, pl_q;

  logic accept;
  logic issue;
  logic last_step;
  logic out_wr;

  assign issue     = (state_q == S_ISSUE);
  assign last_step = (addr_q == len_q - 1'b1);
  assign out_wr    = pv_q[2] & pl_q[2];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    zero_d  = zero_q;
    gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    accept  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        accept = bus.start;
        if (accept) begin
          len_d   = bus.cfg_len;
          mask_d  = bus.cfg_lane_mask;
          addr_d  = '0;
          zero_d  = (bus.cfg_len == '0);
          state_d = (bus.cfg_len == '0) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        // Gap is loaded on the way into ISSUE so it is already counting during the issue cycle.
        if (bus.op_vld && gap_q == '0) begin
          state_d = S_ISSUE;
          gap_d   = GAP_LOAD;
        end
      end
      S_ISSUE: begin
        if (last_step) begin
          state_d = S_DRAIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (zero_q || out_wr) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
      zero_q  <= 1'b0;
      pv_q    <= '0;
      pf_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      zero_q  <= zero_d;
      pv_q    <= {pv_q[1:0], issue};
      pf_q    <= {pf_q[1:0], addr_q == '0};
      pl_q    <= {pl_q[1:0], last_step};
    end
  end

  assign bus.op_addr  = addr_q;
  assign bus.mac_en   = issue ? mask_q : '0;
  assign bus.psum_sel = pv_q[1] & ~pf_q[1];
  assign bus.acc_ld   = pv_q[2] & ~pl_q[2];
  assign bus.out_wr   = out_wr;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (state_q == S_WAIT && !bus.op_vld && gap_q == '0 && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign bus.perf_stall = perf_q;
`endif
endmodule
